sys_mem_resp: RTL
=================

# sys_mem_resp

- System-memory responder for the CVP14 vector processor's Addr/RD/WR/DataIn/DataOut bus.
- Holds program and data words in an internal RAM that is preloaded through a streaming load port while the processor is held in reset.
- After the load it releases the processor and serves its single-word fetches, SST stores, and 16-word VLD/VST bursts with fixed one-cycle read latency.
- Also keeps sticky error flags and saturating access counters for the bench and debug.

## Interface
Parameters:
- AW, 10, internal RAM address width; depth = 2**AW words.
- RELEASE_CYC, 2, cycles the processor reset stays asserted after the load completes, range 1..15.

Ports:
- Clk  in  1  system clock; all bus and load signals are sampled on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Addr  in  16  processor word address.
- RD  in  1  processor read request (level).
- WR  in  1  processor write request (level).
- WData  in  16  write data, driven by the processor's DataOut.
- RData  out  16  read data, driving the processor's DataIn.
- CpuReset  out  1  active-high reset for the processor.
- LdValid  in  1  load word valid.
- LdReady  out  1  load word accepted when LdValid && LdReady.
- LdAddr  in  AW  load word address.
- LdData  in  16  load word data.
- LdLast  in  1  qualifies the final load word.
- RangeErr  out  1  sticky: an access hit Addr[15:AW] != 0.
- ConflictErr  out  1  sticky: RD and WR were both high in the same cycle.
- RdCount  out  16  count of accepted processor reads, saturates at 16'hFFFF.
- WrCount  out  16  count of accepted processor writes, saturates at 16'hFFFF.

## Operation
State machine: LOAD, RELEASE, RUN.

- **Reset (Reset_n low, asynchronous):**
  - state=LOAD; CpuReset=1; LdReady=0 during reset, then 1 from the first edge after release.
  - RData=16'h0000; RangeErr=0; ConflictErr=0; RdCount=0; WrCount=0.
  - RAM contents are not cleared.
- **LOAD:**
  - Each accepted word performs ram[LdAddr] <= LdData.
  - RD, WR and Addr are ignored.
  - An accepted word with LdLast=1 moves to RELEASE on the next edge and drops LdReady to 0.
  - LdLast without LdValid is ignored.
- **RELEASE:**
  - CpuReset stays 1 for exactly RELEASE_CYC cycles, then RUN.
  - The release counter is a 4-bit down-counter.
- **RUN:**
  - CpuReset=0; LdReady=0; the load port is ignored.
  - RUN is left only by Reset_n.
- **Processor write (RUN, WR=1, RD=0, in-range):** ram[Addr[AW-1:0]] <= WData; WrCount++.
- **Processor read (RUN, RD=1, WR=0, in-range):**
  - RData <= ram[Addr] on the same edge; RdCount++.
  - A read that follows a write to the same address on the previous edge returns the newly written value; the RAM is write-first.
- **Burst reads:**
  - RD held high while Addr changes every cycle returns one word per cycle, each one cycle later.
  - No burst counter is kept; every cycle is an independent access.
- **Both RD and WR high:**
  - The write is performed; the read is suppressed; RData holds its value.
  - ConflictErr set; WrCount++ only.
- **Out of range (Addr[15:AW] != 0) with RD or WR:**
  - A write is dropped.
  - A read returns 16'h0000.
  - RangeErr set; counters are not incremented.
- **Idle (RD=WR=0):** RData holds its last value; the processor's VST/VLD tail timing relies on this.

## Timing
- Read latency is 1 cycle: RD/Addr sampled at edge N gives RData valid after edge N and held until the next accepted read.
- A write takes effect at the sampling edge.
- Load accept takes 1 cycle per word; there is no backpressure other than LdReady during non-LOAD states.
- Load end to CpuReset low is RELEASE_CYC+1 edges after the LdLast handshake edge.
- Reset_n asserted mid-burst:
  - Immediately forces CpuReset=1, LdReady=0, RData=0.
  - The in-flight access is lost; the RAM write on that edge is not guaranteed.
- Counter saturation: at 16'hFFFF further accesses leave the counter unchanged.

## Structure
- Shared package cvp14_pkg holds:
  - the state enum (LOAD, RELEASE, RUN);
  - the DATA_W=16 and BUS_AW=16 constants;
  - the reset-value constant for RData.
- One sub-module, sys_mem_ram:
  - 2**AW x 16 RAM with one write port and one registered read port, write-first.
  - The write port is muxed between the load port (LOAD) and the processor (RUN).
- The FSM, error flags and counters live in sys_mem_resp.

## Test plan
- **Load and release:**
  - Stimulus: with RELEASE_CYC=2, load 4 words (addr 0..3 = 16'h7012, 16'h6104, 16'hF000, 16'h8FFD) with LdLast on the fourth.
  - Response: LdReady drops the next cycle; CpuReset falls exactly 3 edges after the LdLast edge; a read of addr 2 in RUN returns 16'hF000 one cycle later.
- **VST then VLD burst:**
  - Stimulus: write addresses 16'h0100..16'h010F with 16'h1000+i, then hold RD with addresses 16'h0100..16'h010F.
  - Response: RData sequence 16'h1000..16'h100F, one per cycle, 1-cycle lag; RdCount=16; WrCount=16.
- **Write-then-read same address:**
  - Stimulus: WR addr 5 = 16'hBEEF, then RD addr 5 on the next edge.
  - Response: RData=16'hBEEF.
- **Conflict:**
  - Stimulus: RD=WR=1, addr 9, WData=16'h00AA.
  - Response: ConflictErr=1; ram[9]=16'h00AA; RData unchanged; WrCount+1; RdCount unchanged.
- **Out of range (AW=10):**
  - Stimulus: WR to 16'h0400 = 16'h1234, then RD of 16'h0400.
  - Response: RangeErr=1; RData=16'h0000; ram[0] unchanged; counters unchanged.
- **Reset mid-burst:**
  - Stimulus: drop Reset_n during a 16-word read burst.
  - Response: CpuReset=1, RData=0, state LOAD, flags and counters zero; RAM contents from before the burst still read back after a reload-less LdLast handshake.

Source files
------------

// File: rtl/cvp14_pkg.sv
// Shared definitions for the CVP14 system-memory responder.
// Contents: responder state enum, bus/data widths, read-data reset value,
// and a saturating increment helper for the 16-bit access counters.
package cvp14_pkg;

    localparam int DATA_W = 16;
    localparam int BUS_AW = 16;

    localparam logic [DATA_W-1:0] RDATA_RST = 16'h0000;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } mem_state_e;

    // Counter step that sticks at all-ones instead of wrapping.
    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] val);
        logic [DATA_W-1:0] res;
        if (val == 16'hFFFF) begin
            res = val;
        end else begin
            res = val + 16'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/sys_mem_ram.sv
// Single write port / single registered read port RAM, 2**AW x 16, write-first.
// Ports:
//   clk, rst_n        clock, async active-low reset (read register only)
//   we, waddr, wdata  write port
//   re, raddr         read request; data appears on rdata after the edge
//   rclr              forces rdata to zero on the edge (out-of-range read)
//   rdata             registered read data, held while no read/clear occurs
module sys_mem_ram
    import cvp14_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic              rclr,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [0:(2**AW)-1];
    logic [DATA_W-1:0] rdata_r;

    // Storage array: no reset so contents survive a processor restart.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read register: bypasses a same-edge write to the same address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= RDATA_RST;
        end else if (rclr) begin
            rdata_r <= RDATA_RST;
        end else if (re) begin
            rdata_r <= (we && (waddr == raddr)) ? wdata : mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/sys_mem_resp.sv
// System-memory responder for the CVP14 processor bus.
// Preloads the RAM through a streaming load port while holding the processor
// in reset, releases it RELEASE_CYC cycles later, then serves single-cycle
// reads/writes with one-cycle read latency.
// Ports:
//   Clk, Reset_n                     clock, async active-low reset
//   Addr, RD, WR, WData, RData       processor bus
//   CpuReset                         active-high processor reset
//   LdValid/LdReady/LdAddr/LdData/LdLast  load stream
//   RangeErr, ConflictErr            sticky error flags
//   RdCount, WrCount                 saturating accepted-access counters
module sys_mem_resp
    import cvp14_pkg::*;
#(
    parameter int AW          = 10,
    parameter int RELEASE_CYC = 2
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [BUS_AW-1:0] Addr,
    input  logic              RD,
    input  logic              WR,
    input  logic [DATA_W-1:0] WData,
    output logic [DATA_W-1:0] RData,
    output logic              CpuReset,
    input  logic              LdValid,
    output logic              LdReady,
    input  logic [AW-1:0]     LdAddr,
    input  logic [DATA_W-1:0] LdData,
    input  logic              LdLast,
    output logic              RangeErr,
    output logic              ConflictErr,
    output logic [DATA_W-1:0] RdCount,
    output logic [DATA_W-1:0] WrCount
);

    localparam logic [3:0] REL_LOAD = 4'(RELEASE_CYC);

    mem_state_e        state_r, state_nxt_s;
    logic [3:0]        rel_cnt_r, rel_cnt_nxt_s;
    logic              ld_ready_r, cpu_reset_r;
    logic              range_err_r, conflict_err_r;
    logic [DATA_W-1:0] rd_count_r, wr_count_r;

    logic              run_s, in_range_s, ld_acc_s;
    logic              proc_we_s, proc_re_s, rclr_s;
    logic              ram_we_s;
    logic [AW-1:0]     ram_waddr_s;
    logic [DATA_W-1:0] ram_wdata_s;

    assign run_s      = (state_r == ST_RUN);
    assign in_range_s = ((Addr >> AW) == 16'd0);
    assign ld_acc_s   = (state_r == ST_LOAD) && LdValid && ld_ready_r;
    // A conflicting RD+WR performs only the write.
    assign proc_we_s  = run_s && WR && in_range_s;
    assign proc_re_s  = run_s && RD && !WR && in_range_s;
    assign rclr_s     = run_s && RD && !WR && !in_range_s;

    // Write port mux: load stream in LOAD, processor in RUN.
    always_comb begin
        ram_we_s    = 1'b0;
        ram_waddr_s = Addr[AW-1:0];
        ram_wdata_s = WData;
        if (ld_acc_s) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = LdAddr;
            ram_wdata_s = LdData;
        end else begin
            ram_we_s    = proc_we_s;
        end
    end

    sys_mem_ram #(.AW(AW)) u_ram (
        .clk   (Clk),
        .rst_n (Reset_n),
        .we    (ram_we_s),
        .waddr (ram_waddr_s),
        .wdata (ram_wdata_s),
        .re    (proc_re_s),
        .rclr  (rclr_s),
        .raddr (Addr[AW-1:0]),
        .rdata (RData)
    );

    // Next-state logic: LOAD until the last word, counted RELEASE, then RUN forever.
    always_comb begin
        state_nxt_s   = state_r;
        rel_cnt_nxt_s = rel_cnt_r;
        case (state_r)
            ST_LOAD: begin
                if (ld_acc_s && LdLast) begin
                    state_nxt_s   = ST_RELEASE;
                    rel_cnt_nxt_s = REL_LOAD;
                end else begin
                    state_nxt_s   = ST_LOAD;
                end
            end
            ST_RELEASE: begin
                if (rel_cnt_r <= 4'd1) begin
                    state_nxt_s   = ST_RUN;
                    rel_cnt_nxt_s = 4'd0;
                end else begin
                    rel_cnt_nxt_s = rel_cnt_r - 4'd1;
                end
            end
            ST_RUN: begin
                state_nxt_s = ST_RUN;
            end
            default: begin
                state_nxt_s   = ST_LOAD;
                rel_cnt_nxt_s = 4'd0;
            end
        endcase
    end

    // State, handshake and processor-reset registers.
    // CpuReset follows the previous state, giving one extra cycle after RUN entry.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r     <= ST_LOAD;
            rel_cnt_r   <= 4'd0;
            ld_ready_r  <= 1'b0;
            cpu_reset_r <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            rel_cnt_r   <= rel_cnt_nxt_s;
            ld_ready_r  <= (state_nxt_s == ST_LOAD);
            cpu_reset_r <= (state_r != ST_RUN);
        end
    end

    // Sticky error flags and saturating access counters.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            range_err_r    <= 1'b0;
            conflict_err_r <= 1'b0;
            rd_count_r     <= 16'h0000;
            wr_count_r     <= 16'h0000;
        end else begin
            if (run_s && (RD || WR) && !in_range_s) begin
                range_err_r <= 1'b1;
            end
            if (run_s && RD && WR) begin
                conflict_err_r <= 1'b1;
            end
            if (proc_re_s) begin
                rd_count_r <= sat_inc(rd_count_r);
            end
            if (proc_we_s) begin
                wr_count_r <= sat_inc(wr_count_r);
            end
        end
    end

    assign LdReady     = ld_ready_r;
    assign CpuReset    = cpu_reset_r;
    assign RangeErr    = range_err_r;
    assign ConflictErr = conflict_err_r;
    assign RdCount     = rd_count_r;
    assign WrCount     = wr_count_r;

endmodule
